// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate back end: FSM state encoding
// and default datapath widths.
package mac_pkg;

  localparam int MAC_PROD_W = 32;
  localparam int MAC_ACC_W  = 40;
  localparam int MAC_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } mac_state_e;

endpackage : mac_pkg

// File: rtl/mac_accumulator_if.sv
// Product-in / sum-out valid-ready handshakes of the MAC accumulator.
// The block itself uses the slave modport; the product source and sum consumer use master.
interface mac_accumulator_if
  import mac_pkg::*;
#(
  parameter int PROD_W = MAC_PROD_W,
  parameter int ACC_W  = MAC_ACC_W
);

  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data;

  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc_data;

  modport master (
    output prod_valid, prod_data, acc_ready,
    input  prod_ready, acc_valid, acc_data
  );

  modport slave (
    input  prod_valid, prod_data, acc_ready,
    output prod_ready, acc_valid, acc_data
  );

endinterface : mac_accumulator_if

// File: rtl/mac_acc_add.sv
// Combinational accumulate step: acc + zero-extended product, with carry-out.
// MAC_ACC_SATURATE_EN defined: an overflowing sum clamps to all ones; otherwise it wraps.
module mac_acc_add
  import mac_pkg::*;
#(
  parameter int PROD_W = MAC_PROD_W,
  parameter int ACC_W  = MAC_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  acc_next,
  output logic              carry
);

  if (ACC_W < PROD_W) begin : g_width_check
    $error("mac_acc_add: ACC_W must be >= PROD_W");
  end

  // One extra bit so the carry-out is visible as the overflow indication.
  logic [ACC_W:0] sum;

  assign sum   = {1'b0, acc} + (ACC_W + 1)'(prod);
  assign carry = sum[ACC_W];

`ifdef MAC_ACC_SATURATE_EN
  assign acc_next = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

endmodule : mac_acc_add

// File: rtl/mac_accumulator.sv
// Streaming MAC back end: sums len products from the multiplier, then holds the sum
// until taken. Optional clamp-on-overflow is selected by MAC_ACC_SATURATE_EN.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = MAC_PROD_W,
  parameter int ACC_W  = MAC_ACC_W,
  parameter int LEN_W  = MAC_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  mac_accumulator_if.slave bus,
  output logic             busy,
  output logic             overflow
);

  mac_state_e       state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic             ovf_q,   ovf_d;

  logic [ACC_W-1:0] add_next;
  logic             add_carry;
  logic             prod_hs;

  mac_acc_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc      (acc_q),
    .prod     (bus.prod_data),
    .acc_next (add_next),
    .carry    (add_carry)
  );

  // Handshake outputs decode registered state only, so no input-to-output path exists.
  assign bus.prod_ready = (state_q == ST_ACCUM);
  assign bus.acc_valid  = (state_q == ST_HOLD);
  assign bus.acc_data   = acc_q;
  assign busy           = (state_q != ST_IDLE);
  assign overflow       = ovf_q;

  assign prod_hs = bus.prod_valid & bus.prod_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            count_d = len;
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end

      ST_ACCUM: begin
        if (prod_hs) begin
          acc_d   = add_next;
          ovf_d   = ovf_q | add_carry;
          count_d = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) begin
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (bus.acc_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Reset is synchronous: a mid-job reset abandons the job at the next edge.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule : mac_accumulator

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator: a 40-bit instance for the main
// scenarios and a 33-bit instance for the overflow/saturation boundary.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start,   start33;
  logic [7:0]  len,     len33;
  logic        busy,    busy33;
  logic        overflow, overflow33;

  int checks = 0;
  int errors = 0;

  mac_accumulator_if #(.PROD_W(32), .ACC_W(40)) bus ();
  mac_accumulator_if #(.PROD_W(32), .ACC_W(33)) bus33 ();

  mac_accumulator #(.PROD_W(32), .ACC_W(40), .LEN_W(8)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .bus      (bus.slave),
    .busy     (busy),
    .overflow (overflow)
  );

  mac_accumulator #(.PROD_W(32), .ACC_W(33), .LEN_W(8)) u_dut33 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start33),
    .len      (len33),
    .bus      (bus33.slave),
    .busy     (busy33),
    .overflow (overflow33)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; len = '0; start33 = 1'b0; len33 = '0;
    bus.prod_valid = 1'b0; bus.prod_data = '0; bus.acc_ready = 1'b0;
    bus33.prod_valid = 1'b0; bus33.prod_data = '0; bus33.acc_ready = 1'b0;
    step(); step();
    checks++; if (bus.prod_ready !== 1'b0) begin errors++; $display("FAIL reset_prod_ready: got %b want 0", bus.prod_ready); end
    checks++; if (bus.acc_valid !== 1'b0) begin errors++; $display("FAIL reset_acc_valid: got %b want 0", bus.acc_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (bus.acc_data !== 40'h0) begin errors++; $display("FAIL reset_acc_data: got %h want 0", bus.acc_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_job();
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    checks++; if (bus.prod_ready !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_accum_state: got ready=%b busy=%b want 1 1", bus.prod_ready, busy); end
    for (int i = 1; i <= 4; i++) begin
      bus.prod_valid = 1'b1;
      bus.prod_data  = 32'(i);
      step();
    end
    bus.prod_valid = 1'b0;
    checks++; if (bus.acc_valid !== 1'b1) begin errors++; $display("FAIL single_acc_valid: got %b want 1", bus.acc_valid); end
    checks++; if (bus.acc_data !== 40'd10) begin errors++; $display("FAIL single_sum: got %0d want 10", bus.acc_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL single_overflow: got %b want 0", overflow); end
    checks++; if (bus.prod_ready !== 1'b0) begin errors++; $display("FAIL single_hold_ready: got %b want 0", bus.prod_ready); end
    bus.acc_ready = 1'b1;
    step();
    bus.acc_ready = 1'b0;
    checks++; if (busy !== 1'b0 || bus.acc_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b valid=%b want 0 0", busy, bus.acc_valid); end
  endtask

  task automatic test_stalls();
    logic [4:0] pv_pattern;
    pv_pattern = 5'b10101;
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.prod_valid = pv_pattern[4-i];
      bus.prod_data  = 32'hFFFE_0001;
      step();
      if (i < 4) begin
        checks++; if (busy !== 1'b1 || bus.acc_valid !== 1'b0) begin errors++; $display("FAIL stall_accum_%0d: got busy=%b valid=%b want 1 0", i, busy, bus.acc_valid); end
      end
    end
    bus.prod_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.acc_valid !== 1'b1 || bus.acc_data !== 40'h2_FFFA_0003) begin errors++; $display("FAIL stall_hold_%0d: got valid=%b data=%h want 1 2fffa0003", i, bus.acc_valid, bus.acc_data); end
      step();
    end
    bus.acc_ready = 1'b1;
    step();
    bus.acc_ready = 1'b0;
    checks++; if (busy !== 1'b0 || bus.acc_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got busy=%b valid=%b want 0 0", busy, bus.acc_valid); end
  endtask

  task automatic test_zero_len();
    start = 1'b1; len = 8'd0;
    step();
    start = 1'b0;
    checks++; if (bus.acc_valid !== 1'b1 || bus.acc_data !== 40'h0) begin errors++; $display("FAIL zero_len_result: got valid=%b data=%h want 1 0", bus.acc_valid, bus.acc_data); end
    // A start pulsed during HOLD must not disturb the pending result.
    start = 1'b1; len = 8'd5;
    step();
    start = 1'b0;
    checks++; if (bus.acc_valid !== 1'b1 || bus.prod_ready !== 1'b0) begin errors++; $display("FAIL hold_start_ignored: got valid=%b ready=%b want 1 0", bus.acc_valid, bus.prod_ready); end
    bus.acc_ready = 1'b1;
    step();
    bus.acc_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_len_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_overflow();
    logic [32:0] exp_sum;
`ifdef MAC_ACC_SATURATE_EN
    exp_sum = 33'h1_FFFF_FFFF;
`else
    exp_sum = 33'h0_FFFF_FFFD;
`endif
    start33 = 1'b1; len33 = 8'd3;
    step();
    start33 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus33.prod_valid = 1'b1;
      bus33.prod_data  = 32'hFFFF_FFFF;
      step();
    end
    bus33.prod_valid = 1'b0;
    checks++; if (overflow33 !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow33); end
    checks++; if (bus33.acc_valid !== 1'b1 || bus33.acc_data !== exp_sum) begin errors++; $display("FAIL ovf_result: got valid=%b data=%h want 1 %h", bus33.acc_valid, bus33.acc_data, exp_sum); end
    bus33.acc_ready = 1'b1;
    step();
    bus33.acc_ready = 1'b0;
    checks++; if (overflow33 !== 1'b1) begin errors++; $display("FAIL ovf_sticky_idle: got %b want 1", overflow33); end
    // The next job start clears the sticky flag.
    start33 = 1'b1; len33 = 8'd1;
    step();
    start33 = 1'b0;
    checks++; if (overflow33 !== 1'b0) begin errors++; $display("FAIL ovf_clear_on_start: got %b want 0", overflow33); end
    bus33.prod_valid = 1'b1;
    bus33.prod_data  = 32'd1;
    step();
    bus33.prod_valid = 1'b0;
    checks++; if (bus33.acc_data !== 33'd1 || overflow33 !== 1'b0) begin errors++; $display("FAIL ovf_next_job: got data=%h ovf=%b want 1 0", bus33.acc_data, overflow33); end
    bus33.acc_ready = 1'b1;
    step();
    bus33.acc_ready = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    start = 1'b1; len = 8'd5;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.prod_valid = 1'b1;
      bus.prod_data  = 32'd100;
      step();
    end
    rst_n = 1'b0;
    step();
    bus.prod_valid = 1'b0;
    checks++; if (bus.prod_ready !== 1'b0 || bus.acc_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || bus.acc_data !== 40'h0) begin
      errors++; $display("FAIL midreset_outputs: got ready=%b valid=%b busy=%b ovf=%b data=%h want all 0", bus.prod_ready, bus.acc_valid, busy, overflow, bus.acc_data);
    end
    rst_n = 1'b1;
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    bus.prod_valid = 1'b1;
    bus.prod_data  = 32'd7;
    step();
    bus.prod_valid = 1'b0;
    checks++; if (bus.acc_valid !== 1'b1 || bus.acc_data !== 40'd7) begin errors++; $display("FAIL midreset_new_job: got valid=%b data=%0d want 1 7", bus.acc_valid, bus.acc_data); end
    bus.acc_ready = 1'b1;
    step();
    bus.acc_ready = 1'b0;
  endtask

  // Sixteen A*B products (the multiplier's function) at full throughput, started
  // in the single idle cycle right after the previous result handshake.
  task automatic test_back_to_back();
    logic [15:0] a, b;
    logic [39:0] ref_sum;
    ref_sum = '0;
    start = 1'b1; len = 8'd16;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      if (i == 0) begin a = 16'hFFFF; b = 16'hFFFF; end
      ref_sum = ref_sum + 40'(32'(a) * 32'(b));
      bus.prod_valid = 1'b1;
      bus.prod_data  = 32'(a) * 32'(b);
      step();
      if (i < 15) begin
        checks++; if (bus.prod_ready !== 1'b1) begin errors++; $display("FAIL e2e_throughput_%0d: got ready=%b want 1", i, bus.prod_ready); end
      end
    end
    bus.prod_valid = 1'b0;
    checks++; if (bus.acc_valid !== 1'b1 || bus.acc_data !== ref_sum) begin errors++; $display("FAIL e2e_sum: got valid=%b data=%h want 1 %h", bus.acc_valid, bus.acc_data, ref_sum); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL e2e_overflow: got %b want 0", overflow); end
    bus.acc_ready = 1'b1;
    step();
    bus.acc_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL e2e_idle: got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_stalls();
    test_zero_len();
    test_overflow();
    test_reset_mid_job();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mac_accumulator
